pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 The module SHALL have parameter STEP_DIV, default 256, giving the clock cycles per duty step (legal range 1..65535).
REQ-002 The module SHALL have parameter DUTY_W, default 8, giving the duty value width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port cmd_valid, input, 1 bit, fade command present.
REQ-006 The module SHALL have port cmd_ready, output, 1 bit, command accepted this cycle if cmd_valid is high.
REQ-007 The module SHALL have port cmd_target, input, DUTY_W bits, requested final duty.
REQ-008 The module SHALL have port cmd_instant, input, 1 bit, jump to the target without ramping.
REQ-009 The module SHALL have port value, output, DUTY_W bits, duty code driving the pwm block's value input.
REQ-010 The module SHALL have port busy, output, 1 bit, high while a ramp is in progress.
REQ-011 The module SHALL have port done, output, 1 bit, one-cycle pulse when value reaches the target.

Function
REQ-012 The module SHALL implement FSM states IDLE, RAMP_UP and RAMP_DOWN.
REQ-013 The module SHALL drive cmd_ready = (state == IDLE), combinationally from state only; acceptance is cmd_valid & cmd_ready at a clk edge.
REQ-014 On acceptance with cmd_instant=1 or cmd_target==value, the module SHALL load value<=cmd_target at that edge, stay in IDLE and pulse done in the following cycle.
REQ-015 On acceptance with cmd_target>value (cmd_instant=0), the module SHALL latch the target, go to RAMP_UP and clear the step counter.
REQ-016 On acceptance with cmd_target<value (cmd_instant=0), the module SHALL latch the target, go to RAMP_DOWN and clear the step counter.
REQ-017 In RAMP_UP/RAMP_DOWN the step counter SHALL count 0..STEP_DIV-1 and wrap, asserting an internal tick when it wraps, so the first step occurs STEP_DIV cycles after acceptance.
REQ-018 On each applied tick, the module SHALL change value by exactly +1 (RAMP_UP) or -1 (RAMP_DOWN).
REQ-019 At the edge where value becomes the latched target, the module SHALL return to IDLE, and done SHALL be high for exactly the next cycle.
REQ-020 value SHALL never wrap past 0 or 2^DUTY_W-1, because steps only move toward an in-range target.
REQ-021 busy SHALL equal (state != IDLE); cmd_valid during busy SHALL be ignored and not latched.
REQ-022 A command accepted in the same cycle done is high SHALL be processed normally.

Reset
REQ-023 While rst_n=0, the module SHALL immediately force state=IDLE, value=0, latched target=0, step counter=0, done=0, busy=0 and cmd_ready=1.
REQ-024 Reset asserted mid-ramp SHALL abort the ramp with no done pulse.

Configuration
REQ-025 The module SHALL support the macro PWM_FADE_SYNC_EN.
REQ-026 With PWM_FADE_SYNC_EN defined, the module SHALL add input port period_start (1 bit, pulse at PWM period boundary).
REQ-027 With PWM_FADE_SYNC_EN defined, a tick SHALL set a pending flag, and the step SHALL be applied only on a cycle with pending & period_start; period_start without pending SHALL be ignored.
REQ-028 With PWM_FADE_SYNC_EN defined, an instant load SHALL also wait for the next period_start, remaining in IDLE with cmd_ready=0 until applied.
REQ-029 With PWM_FADE_SYNC_EN undefined, there SHALL be no period_start port and steps SHALL be applied on the tick cycle itself.

Structure
REQ-030 Package pwm_fade_pkg SHALL hold the FSM state enum and the DUTY_W default constant.
REQ-031 The step counter and tick generation SHALL be sub-module pwm_fade_tick (inputs clk, rst_n, clear, enable; output tick).

Verification (STEP_DIV=4, DUTY_W=8, macro undefined unless stated)
REQ-032 Reset, then target=5, instant=0 -> value steps 1..5 at cycles 4,8,12,16,20 after acceptance; done pulses once after value=5; busy high throughout the ramp.
REQ-033 From value=5: target=2 -> value 4,3,2 at 4-cycle spacing; single done pulse; cmd_ready=0 during the ramp.
REQ-034 target=200, instant=1 -> value=200 on the next edge, done pulses the following cycle, busy never asserts.
REQ-035 Mid-ramp: a new cmd_valid is ignored and value continues to the original target; rst_n pulled low mid-ramp -> value=0, IDLE, no done.
REQ-036 target==value (30->30) -> no state change, done pulse next cycle; target=255 from 254 -> value=255 with no wrap.
REQ-037 With PWM_FADE_SYNC_EN defined, period_start every 10 cycles -> each step lands on a period_start cycle; a 0->3 ramp completes after the third qualifying period_start.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// Shared types and defaults for the PWM fade controller.
package pwm_fade_pkg;

   localparam int DUTY_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_fade_tick.sv
// Step-rate divider: counts 0..STEP_DIV-1 while enabled and pulses tick on the wrap cycle.
module pwm_fade_tick #(
   parameter int STEP_DIV = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = enable & ~clear & (cnt == LAST);

   // Held at zero outside a ramp so every ramp starts with a full STEP_DIV interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || !enable || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade controller: ramps value one code per STEP_DIV cycles toward a commanded target.
// Optional macro PWM_FADE_SYNC_EN aligns every value update to the PWM period_start pulse.
module pwm_fade_ctrl
   import pwm_fade_pkg::*;
#(
   parameter int STEP_DIV = 256,
   parameter int DUTY_W   = DUTY_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic              cmd_instant,
`ifdef PWM_FADE_SYNC_EN
   input  logic              period_start,
`endif
   output logic [DUTY_W-1:0] value,
   output logic              busy,
   output logic              done
);

   state_t            state, state_d;
   logic [DUTY_W-1:0] target, target_d, value_d;
   logic              done_d;
   logic              accept, tick, step;

`ifdef PWM_FADE_SYNC_EN
   logic step_pend, step_pend_d;
   logic load_pend, load_pend_d;

   // A tick only arms the step; the update itself waits for the period boundary.
   assign step        = step_pend & period_start;
   assign step_pend_d = busy & (tick | (step_pend & ~period_start));
   assign cmd_ready   = (state == IDLE) & ~load_pend;
`else
   assign step      = tick;
   assign cmd_ready = (state == IDLE);
`endif

   assign busy   = (state != IDLE);
   assign accept = cmd_valid & cmd_ready;

   pwm_fade_tick #(
      .STEP_DIV (STEP_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (busy),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         value  <= '0;
         target <= '0;
         done   <= 1'b0;
`ifdef PWM_FADE_SYNC_EN
         step_pend <= 1'b0;
         load_pend <= 1'b0;
`endif
      end else begin
         state  <= state_d;
         value  <= value_d;
         target <= target_d;
         done   <= done_d;
`ifdef PWM_FADE_SYNC_EN
         step_pend <= step_pend_d;
         load_pend <= load_pend_d;
`endif
      end
   end

   always_comb begin
      state_d  = state;
      target_d = target;
      value_d  = value;
      done_d   = 1'b0;
`ifdef PWM_FADE_SYNC_EN
      load_pend_d = load_pend;
`endif
      case (state)
         IDLE: begin
`ifdef PWM_FADE_SYNC_EN
            if (load_pend && period_start) begin
               value_d     = target;
               done_d      = 1'b1;
               load_pend_d = 1'b0;
            end
`endif
            if (accept) begin
               target_d = cmd_target;
               if (cmd_instant || cmd_target == value) begin
`ifdef PWM_FADE_SYNC_EN
                  load_pend_d = 1'b1;
`else
                  value_d = cmd_target;
                  done_d  = 1'b1;
`endif
               end else if (cmd_target > value) begin
                  state_d = RAMP_UP;
               end else begin
                  state_d = RAMP_DOWN;
               end
            end
         end
         // Steps always move toward an in-range target, so value cannot wrap.
         RAMP_UP: begin
            if (step) begin
               value_d = value + DUTY_W'(1);
               if (value_d == target) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         RAMP_DOWN: begin
            if (step) begin
               value_d = value - DUTY_W'(1);
               if (value_d == target) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl (STEP_DIV=4, DUTY_W=8, default build).
module tb_pwm_fade_ctrl;

   localparam int SD = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_instant = 1'b0;
   logic [DW-1:0] cmd_target = '0;
   logic          cmd_ready, busy, done;
   logic [DW-1:0] value;

   pwm_fade_ctrl #(
      .STEP_DIV (SD),
      .DUTY_W   (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_target  (cmd_target),
      .cmd_instant (cmd_instant),
      .value       (value),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected observable events: a value change or a done pulse, with the cycle it must appear in.
   typedef struct {
      bit is_done;
      int data;
      int at;
   } ev_t;
   ev_t q[$];

   int            vectors = 0;
   int            miscompares = 0;
   bit            mon_en = 1'b0;
   int            win_lo = 0;
   int            win_hi = 0;
   int            model_value = 0;
   logic [DW-1:0] prev_value = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input int exp_data, input int exp_at);
      vectors++;
      miscompares++;
      $display("FAIL %s: expected data %0d at cycle %0d, now cycle %0d, value %0d",
               name, exp_data, exp_at, cyc, value);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         while (q.size() > 0 && q[0].at < cyc) begin
            fail_now(q[0].is_done ? "missed_done" : "missed_step", q[0].data, q[0].at);
            void'(q.pop_front());
         end
         if (value !== prev_value) begin
            if (q.size() == 0 || q[0].is_done) begin
               fail_now("unexpected_value_change", int'(prev_value), cyc);
            end else begin
               chk("step_value", 32'(value), 32'(q[0].data));
               chk("step_cycle", 32'(cyc), 32'(q[0].at));
               void'(q.pop_front());
            end
         end
         prev_value <= value;
         if (done !== 1'b0) begin
            if (q.size() == 0 || !q[0].is_done) begin
               fail_now("unexpected_done", int'(value), cyc);
            end else begin
               chk("done_value", 32'(value), 32'(q[0].data));
               chk("done_cycle", 32'(cyc), 32'(q[0].at));
               void'(q.pop_front());
            end
         end
         chk("busy", 32'(busy), 32'(cyc >= win_lo && cyc < win_hi));
         chk("cmd_ready", 32'(cmd_ready), 32'(!(cyc >= win_lo && cyc < win_hi)));
      end
   end

   // Called at a falling edge; the command is accepted at the next rising edge.
   task automatic do_cmd(input int t, input bit inst, input bit noise);
      int a, n, dir;
      a           = cyc + 1;
      cmd_valid   = 1'b1;
      cmd_target  = t[DW-1:0];
      cmd_instant = inst;
      if (inst || t == model_value) begin
         if (t != model_value) q.push_back('{1'b0, t, a});
         q.push_back('{1'b1, t, a});
         model_value = t;
         @(negedge clk);
         cmd_valid = 1'b0;
      end else begin
         dir = (t > model_value) ? 1 : -1;
         n   = (t > model_value) ? t - model_value : model_value - t;
         for (int k = 1; k <= n; k++) q.push_back('{1'b0, model_value + dir * k, a + SD * k});
         q.push_back('{1'b1, t, a + SD * n});
         win_lo      = a;
         win_hi      = a + SD * n;
         model_value = t;
         @(negedge clk);
         for (int i = 0; i < SD * n; i++) begin
            cmd_valid   = noise && ($urandom_range(0, 3) == 0);
            cmd_target  = DW'($urandom);
            cmd_instant = 1'($urandom);
            @(negedge clk);
         end
         cmd_valid = 1'b0;
      end
   endtask

   int t_rand;
   bit seen_done;
   bit value_moved;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_value", 32'(value), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      do_cmd(5, 1'b0, 1'b1);
      do_cmd(2, 1'b0, 1'b1);
      do_cmd(200, 1'b1, 1'b0);
      do_cmd(30, 1'b1, 1'b0);
      do_cmd(30, 1'b0, 1'b0);
      do_cmd(254, 1'b1, 1'b0);
      do_cmd(255, 1'b0, 1'b1);
      do_cmd(0, 1'b1, 1'b0);

      repeat (40) begin
         if ($urandom_range(0, 3) == 0) begin
            do_cmd(int'($urandom_range(0, 255)), 1'b1, 1'b0);
         end else begin
            t_rand = model_value + int'($urandom_range(0, 24)) - 12;
            if (t_rand < 0) t_rand = 0;
            if (t_rand > 255) t_rand = 255;
            do_cmd(t_rand, 1'b0, 1'($urandom));
         end
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      // Abort a ramp with reset: value returns to 0 and no done follows.
      do_cmd(10, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      mon_en      = 1'b0;
      cmd_valid   = 1'b1;
      cmd_target  = 8'd40;
      cmd_instant = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("midramp_value", 32'(value), 32'd12);
      chk("midramp_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_value", 32'(value), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst_n       = 1'b1;
      seen_done   = 1'b0;
      value_moved = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done !== 1'b0) seen_done = 1'b1;
         if (value !== 8'd0) value_moved = 1'b1;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      chk("abort_value_held", 32'(value_moved), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
